d_ff: RTL and testbench
=======================

# d_ff

Parameterised positive-edge D flip-flop register with asynchronous active-low reset. It is the state-storage primitive beneath the light/lane FSMs: each FSM instantiates one `d_ff` per state bit, driving `d` from next-state logic and reading present state from `q`. The default configuration is a single bit with a single stage. Optional width, reset value and stage count let the same block serve as a multi-bit register or a short delay line.

## Interface
Parameters:
- `WIDTH`, default 1: data width in bits; legal range is 1 to 32.
- `RESET_VALUE`, default 0 (all bits zero): value loaded into every stage while reset is asserted; truncated to `WIDTH`.
- `STAGES`, default 1: number of register stages in series; legal range is 1 to 8.

Ports (clock and reset listed first here; the positional order is fixed as `(q, d, Reset, Clock)`):
- `Clock`, input, 1 bit: the only clock; all sampling is on the rising edge.
- `Reset`, input, 1 bit: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `q`, output, `WIDTH` bits: registered output, taken from the last stage.
- `d`, input, `WIDTH` bits: data input to stage 0.

## Operation
- Storage is `STAGES` registers, each `WIDTH` bits wide, named stage[0] to stage[STAGES-1].
- `q` is stage[STAGES-1].
- Reset, when `Reset` is 0:
  - Every stage is forced to `RESET_VALUE` immediately, with no clock edge needed.
  - The stages hold that value for as long as `Reset` stays 0; clock edges are ignored.
- Normal operation, when `Reset` is 1, on each rising edge of `Clock`:
  - stage[0] takes `d`.
  - stage[i] takes stage[i-1], for i from 1 to STAGES-1.
- No enable input and no combinational path from `d` to `q`.
- `q` is a pure register output, so `d` may depend combinationally on `q` without forming a loop. This is the FSM feedback case.
- Parameter checks at elaboration: a `WIDTH` or `STAGES` value outside its legal range is a fatal elaboration error.
- No X-propagation masking: an X on `d` is captured as X.

## Timing
- Latency: `q` equals `d` sampled `STAGES` rising edges earlier. With defaults that is 1 cycle.
- Reset assertion: `q` becomes `RESET_VALUE` within the same delta/propagation time as the `Reset` falling edge. It does not wait for `Clock`.
- Reset deassertion: the first capture happens on the first rising `Clock` edge strictly after `Reset` goes to 1.
- Simultaneous `Clock` rising edge and `Reset` falling edge: reset wins, so `q` equals `RESET_VALUE`.
- Simultaneous `Clock` rising edge and `Reset` rising edge: the edge is not a capture edge and `q` stays at `RESET_VALUE`. Integrators must deassert reset away from the active clock edge.
- Reset asserted mid-operation: all in-flight data in every stage is discarded, with no partial shift.
- Power-up before any reset: `q` is undefined. Users must apply reset.

## Test plan
- Default config, async reset: drive `d`=1 and clock until `q`=1. Drive `Reset`=0 between clock edges. `q` must go to 0 before the next `Clock` edge, and stay 0 over 3 further edges while `d`=1.
- Default config, capture: set `Reset`=1 and apply the sequence `d` = 1,0,0,1,1 on successive rising edges. `q` must read 1,0,0,1,1, each value one edge later than its `d`.
- Reset/clock collision: assert the `Reset` falling edge coincident with a `Clock` rising edge while `d`=1. `q` must read 0.
- `WIDTH`=4, `RESET_VALUE`=4'b1010: with reset asserted, `q` must be 4'b1010. After release, `d`=4'b0110 gives `q`=4'b0110 after 1 edge.
- `STAGES`=3: after reset release, pulse `d`=1 for a single cycle. `q` must be 1 for exactly one cycle, 3 edges after the pulse is sampled. Asserting `Reset` mid-flight must clear the pulse so it never appears on `q`.
- FSM feedback: two default instances with d0 = ~q0 and d1 = q1 ^ q0 form a 2-bit counter. After reset, `{q1,q0}` must step 00, 01, 10, 11, 00 on successive edges.

Source files
------------

// File: rtl/d_ff.sv
// d_ff: parameterised positive-edge D flip-flop register with asynchronous
// active-low reset. Serves as the state-storage bit under the light/lane FSMs
// (one instance per state bit) and, with wider WIDTH or more STAGES, as a
// multi-bit register or a short delay line.
//
// Parameters:
//   WIDTH       - data width in bits, 1..32 (default 1)
//   RESET_VALUE - value forced into every stage while Reset is low,
//                 truncated to WIDTH (default 0)
//   STAGES      - number of register stages in series, 1..8 (default 1)
//
// Ports (positional order is fixed as q, d, Reset, Clock):
//   q     - output, WIDTH bits: last stage, a pure register output
//   d     - input,  WIDTH bits: data into stage 0
//   Reset - input, asynchronous active-low reset
//   Clock - input, rising-edge clock
//
// Because q comes straight from a flop, d may be a combinational function of
// q (FSM next-state feedback) without creating a combinational loop.
module d_ff #(
    parameter int          WIDTH       = 1,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter int          STAGES      = 1
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             Reset,
    input  logic             Clock
);

    // Out-of-range configurations stop elaboration outright.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "d_ff: WIDTH=%0d outside legal range 1..32", WIDTH);
        end
        if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
            $fatal(1, "d_ff: STAGES=%0d outside legal range 1..8", STAGES);
        end
    endgenerate

    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] stage [STAGES];

    // Reset is in the sensitivity list so every stage clears immediately on
    // the falling edge of Reset, discarding any in-flight data at once. While
    // Reset stays low the reset branch keeps winning, so clock edges are ignored.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: several configurations share one clock and one reset.
// The reference model keeps, per instance, the history of d values captured
// since the last reset; the expected q is the entry STAGES captures back, or
// the reset value when fewer captures have happened.
module tb_d_ff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        d1b, q1b;          // default config
  logic [3:0]  d4, q4;            // WIDTH=4, RESET_VALUE=4'b1010
  logic        d3, q3;            // STAGES=3
  logic [31:0] d32, q32;          // WIDTH=32, STAGES=8, RESET_VALUE=DEADBEEF
  logic        q_c0, q_c1;        // two-bit counter built from two default flops
  logic        d_c0, d_c1;

  assign d_c0 = ~q_c0;
  assign d_c1 = q_c1 ^ q_c0;

  d_ff u_def (.q(q1b), .d(d1b), .Reset(rst_n), .Clock(clk));
  d_ff #(.WIDTH(4), .RESET_VALUE(32'hA)) u_w4 (.q(q4), .d(d4), .Reset(rst_n), .Clock(clk));
  d_ff #(.STAGES(3)) u_s3 (.q(q3), .d(d3), .Reset(rst_n), .Clock(clk));
  d_ff #(.WIDTH(32), .STAGES(8), .RESET_VALUE(32'hDEAD_BEEF)) u_w32 (.q(q32), .d(d32), .Reset(rst_n), .Clock(clk));
  d_ff u_c0 (.q(q_c0), .d(d_c0), .Reset(rst_n), .Clock(clk));
  d_ff u_c1 (.q(q_c1), .d(d_c1), .Reset(rst_n), .Clock(clk));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: captured-d histories and counter value.
  logic [31:0] h1[$], h4[$], h3[$], h32[$];
  int cnt_model = 0;

  function automatic logic [31:0] exp_def();
    return (h1.size() >= 1) ? h1[h1.size()-1] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_w4();
    return (h4.size() >= 1) ? h4[h4.size()-1] : 32'hA;
  endfunction

  function automatic logic [31:0] exp_s3();
    return (h3.size() >= 3) ? h3[h3.size()-3] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_w32();
    return (h32.size() >= 8) ? h32[h32.size()-8] : 32'hDEAD_BEEF;
  endfunction

  // One rising edge; records what the flops capture when out of reset,
  // then returns 1 time unit after the edge.
  task automatic tick();
    if (rst_n) begin
      h1.push_back({31'b0, d1b});
      h4.push_back({28'b0, d4});
      h3.push_back({31'b0, d3});
      h32.push_back(d32);
      cnt_model = (cnt_model + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    h1.delete(); h4.delete(); h3.delete(); h32.delete();
    cnt_model = 0;
  endtask

  // Called at edge+1: release reset in mid-cycle, away from the clock edge.
  task automatic release_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    d1b = 1'b1; d4 = 4'h0; d3 = 1'b0; d32 = 32'h0;
    rst_n = 1'b0;
    model_clear();
    tick();
    release_reset();
    tick();
    n_cmp++;
    if (q1b !== 1'b1) begin n_bad++; $display("FAIL reset_pre_q: got %b expected 1", q1b); end
    // Assert reset between edges; q must clear without waiting for a clock.
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (q1b !== 1'b0) begin n_bad++; $display("FAIL reset_async_q: got %b expected 0", q1b); end
    n_cmp++;
    if (q4 !== 4'b1010) begin n_bad++; $display("FAIL reset_async_w4: got %b expected 1010", q4); end
    n_cmp++;
    if (q32 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL reset_async_w32: got %h expected deadbeef", q32); end
    n_cmp++;
    if ({q_c1, q_c0} !== 2'b00) begin n_bad++; $display("FAIL reset_async_cnt: got %b expected 00", {q_c1, q_c0}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (q1b !== 1'b0) begin n_bad++; $display("FAIL reset_hold[%0d]: got %b expected 0", k, q1b); end
    end
  endtask

  task automatic test_capture();
    logic [4:0] seq;
    seq = 5'b11001;   // applied LSB first: 1,0,0,1,1
    release_reset();
    for (int k = 0; k < 5; k++) begin
      d1b = seq[k];
      tick();
      n_cmp++;
      if (q1b !== seq[k]) begin n_bad++; $display("FAIL capture[%0d]: got %b expected %b", k, q1b, seq[k]); end
      n_cmp++;
      if (q1b !== exp_def()) begin n_bad++; $display("FAIL capture_model[%0d]: got %b expected %b", k, q1b, exp_def()); end
    end
  endtask

  task automatic test_collision();
    d1b = 1'b1;
    tick();
    // Reset falls in the same time step as the rising edge: reset must win.
    @(posedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (q1b !== 1'b0) begin n_bad++; $display("FAIL collision_q: got %b expected 0", q1b); end
    n_cmp++;
    if (q32 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL collision_w32: got %h expected deadbeef", q32); end
  endtask

  task automatic test_width4();
    d4 = 4'b0110;
    tick();
    n_cmp++;
    if (q4 !== 4'b1010) begin n_bad++; $display("FAIL w4_in_reset: got %b expected 1010", q4); end
    release_reset();
    tick();
    n_cmp++;
    if (q4 !== 4'b0110) begin n_bad++; $display("FAIL w4_capture: got %b expected 0110", q4); end
  endtask

  task automatic test_stages3();
    logic got;
    rst_n = 1'b0;
    model_clear();
    d3 = 1'b0;
    tick();
    release_reset();
    d3 = 1'b1;
    tick();           // edge 1 samples the pulse
    d3 = 1'b0;
    n_cmp++;
    if (q3 !== 1'b0) begin n_bad++; $display("FAIL s3_edge1: got %b expected 0", q3); end
    for (int k = 2; k <= 6; k++) begin
      tick();
      got = q3;
      n_cmp++;
      if (got !== ((k == 3) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL s3_edge%0d: got %b expected %b", k, got, (k == 3)); end
    end
    // Pulse in flight when reset hits: it must never reach q.
    d3 = 1'b1;
    tick();
    d3 = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    release_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (q3 !== 1'b0) begin n_bad++; $display("FAIL s3_flush[%0d]: got %b expected 0", k, q3); end
    end
  endtask

  task automatic test_counter();
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11; want[3] = 2'b00;
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if ({q_c1, q_c0} !== 2'b00) begin n_bad++; $display("FAIL cnt_reset: got %b expected 00", {q_c1, q_c0}); end
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({q_c1, q_c0} !== want[k]) begin n_bad++; $display("FAIL cnt_step[%0d]: got %b expected %b", k, {q_c1, q_c0}, want[k]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 300; n++) begin
      d1b = 1'($urandom_range(0, 1));
      d4  = 4'($urandom_range(0, 15));
      d3  = 1'($urandom_range(0, 1));
      d32 = $urandom;
      if ($urandom_range(0, 24) == 0) begin
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (q32 !== 32'hDEAD_BEEF || q4 !== 4'b1010 || q1b !== 1'b0 || q3 !== 1'b0)
          begin n_bad++; $display("FAIL rand_reset[%0d]: got %b %b %b %h expected 0 1010 0 deadbeef", n, q1b, q4, q3, q32); end
        #2;
        rst_n = 1'b1;
      end
      tick();
      e = exp_def();
      n_cmp++;
      if (q1b !== e[0]) begin n_bad++; $display("FAIL rand_def[%0d]: got %b expected %b", n, q1b, e[0]); end
      e = exp_w4();
      n_cmp++;
      if (q4 !== e[3:0]) begin n_bad++; $display("FAIL rand_w4[%0d]: got %h expected %h", n, q4, e[3:0]); end
      e = exp_s3();
      n_cmp++;
      if (q3 !== e[0]) begin n_bad++; $display("FAIL rand_s3[%0d]: got %b expected %b", n, q3, e[0]); end
      e = exp_w32();
      n_cmp++;
      if (q32 !== e) begin n_bad++; $display("FAIL rand_w32[%0d]: got %h expected %h", n, q32, e); end
      n_cmp++;
      if ({q_c1, q_c0} !== 2'(cnt_model)) begin n_bad++; $display("FAIL rand_cnt[%0d]: got %b expected %0d", n, {q_c1, q_c0}, cnt_model); end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_collision();
    test_width4();
    test_stages3();
    test_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
